rv32v_element_sequencer: RTL and testbench
==========================================

Name: rv32v_element_sequencer

Overview:
- Sits directly downstream of instruction fetch/decode for RV32V OP-V (opcode 1010111) instructions.
- Owns the vl CSR (0xC20) and executes vsetvl-style OP_SETVL instructions.
- Validates each funct3/funct6/vm combination.
- Expands each legal vector op into one micro-op beat per element for the scalar FP/permute datapath, under a valid/ready handshake.

Parameters:
VLMAX, 32, maximum vector length; power of two, 2..256. Derived: VLW = clog2(VLMAX)+1.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept an instruction
instr_word  in  32  raw instruction
instr_rs1_value  in  32  scalar x/f register value for rs1 field
vl  out  VLW  current vl CSR
rd_valid  out  1  one-cycle scalar writeback pulse (SETVL)
rd_addr  out  5  writeback register (vd field)
rd_value  out  32  writeback value
illegal  out  1  one-cycle illegal-instruction pulse
done  out  1  one-cycle instruction-complete pulse
elem_valid  out  1  element beat valid
elem_ready  in  1  downstream accepts beat
elem_funct6  out  6  operation
elem_use_scalar  out  1  operand 1 is elem_scalar, not vs1
elem_scalar  out  32  latched rs1 value
elem_vd / elem_vs1 / elem_vs2  out  5 each  register indices
elem_dst_index  out  VLW-1  destination element index
elem_src_index  out  VLW-1  source element index
elem_src_zero  out  1  source operand reads as zero
elem_last  out  1  final beat of instruction

Behaviour:
- Fields: funct6[31:26], vm[25], vs2[24:20], vs1/rs1/imm[19:15], funct3[14:12], vd[11:7], opcode[6:0]. imm is an unsigned 5-bit slide offset.
- Reset state: IDLE. vl=0; all pulses (rd_valid, illegal, done) and elem_valid = 0. Other outputs = 0.
- Reset mid-instruction aborts it. No further beats. No done pulse.
- FSM states: IDLE, ISSUE.
  - instr_ready = (state==IDLE).
  - Instruction accepted at cycle T when instr_valid && instr_ready.
  - All decode results are registered and appear at T+1.
- Legality (any failure -> illegal=1 at T+1, no beats, vl unchanged, no done):
  - opcode != 1010111 is illegal.
  - Funct3 IVV, MVV, IVX and MVX are illegal.
  - OPFVV: funct6 must be one of vfadd, vfsub, vfmin, vfmax, vfsgnj, vfsgnn, vfsgnx, vfdiv, vfmul, vfmacc, vfnmacc, vfmsac, vfnmsac. vfrdiv is illegal under OPFVV.
  - OPFVF: same set as OPFVV, plus vfrdiv.
  - OPIVI: only vslideup (001110) and vslidedown (001111).
  - vm=0 (masked) is illegal for all non-SETVL ops. vm is ignored for SETVL.
- OP_SETVL:
  - new_vl = min(rs1_value, VLMAX), unsigned 32-bit compare.
  - At T+1: vl=new_vl, rd_valid=1, rd_addr=vd, rd_value=new_vl zero-extended, done=1. State stays IDLE.
  - rd_valid pulses even when vd=0.
- FVV/FVF:
  - dst index e runs 0..vl-1; src index = e.
  - elem_use_scalar = (funct3==FVF).
  - elem_scalar latched at T.
- vslideup:
  - dst runs imm..vl-1; src = e-imm; source register is vs2.
  - Elements below imm are not emitted.
- vslidedown:
  - dst runs 0..vl-1; src = e+imm, computed in VLW+1 bits.
  - If src >= VLMAX: elem_src_zero=1 and elem_src_index=0.
- Zero-beat case: if the element count is 0 (vl==0, or slideup with imm>=vl), done=1 at T+1 and the FSM stays in IDLE.
- Otherwise the FSM enters ISSUE and beat 0 is valid at T+1.
- Beat handshake:
  - A beat advances only when elem_valid && elem_ready.
  - All elem_* outputs hold stable while stalled.
  - Throughput is 1 beat/cycle with elem_ready high.
  - elem_last=1 on the final beat.
- Completion: on the last handshake, elem_valid drops next cycle, done=1 that cycle, and state=IDLE. A new instruction may be accepted in that same cycle.
- vl changes only via SETVL. An in-flight op uses the vl sampled at acceptance.

Test Plan:
- Reset, then SETVL with rs1_value=100 (VLMAX=32), vd=5 -> vl=32; rd_valid, rd_addr=5, rd_value=32 and done all at T+1; no beats.
- vl=4, OPFVV vfadd vd=1 vs1=2 vs2=3 with elem_ready stalled on beat 2 for 3 cycles -> 4 beats with dst=src=0..3, outputs stable during the stall, elem_last on beat 3, done next cycle.
- vl=8, OPIVI vslidedown imm=30 -> 8 beats; dst 0,1 have src 30,31 and src_zero=0; dst 2..7 have src_zero=1.
- vl=8, vslideup imm=3 -> 5 beats, dst 3..7 / src 0..4. Same op with imm=9 -> no beats, done at T+1.
- Illegal cases, each -> illegal pulse, vl unchanged, no done: OPFVV vfrdiv; OPIVI vfadd; vm=0 vfmul; funct3=IVV; opcode 0110011.
- rst asserted mid-ISSUE on beat 2 of 8 -> next cycle elem_valid=0, vl=0, instr_ready=1, no done pulse.

Source files
------------

// File: rtl/rv32v_element_sequencer_if.sv
// Purpose: intake, scalar writeback/status and element-beat bus of the RV32V element sequencer.
// Latency: wiring only, no storage.
// Backpressure: instr_valid/instr_ready on intake, elem_valid/elem_ready on the beat stream.
interface rv32v_element_sequencer_if #(
    parameter int VLMAX = 32
);
    localparam int VLW = $clog2(VLMAX) + 1;

    logic           instr_valid;
    logic           instr_ready;
    logic [31:0]    instr_word;
    logic [31:0]    instr_rs1_value;
    logic [VLW-1:0] vl;
    logic           rd_valid;
    logic [4:0]     rd_addr;
    logic [31:0]    rd_value;
    logic           illegal;
    logic           done;
    logic           elem_valid;
    logic           elem_ready;
    logic [5:0]     elem_funct6;
    logic           elem_use_scalar;
    logic [31:0]    elem_scalar;
    logic [4:0]     elem_vd;
    logic [4:0]     elem_vs1;
    logic [4:0]     elem_vs2;
    logic [VLW-2:0] elem_dst_index;
    logic [VLW-2:0] elem_src_index;
    logic           elem_src_zero;
    logic           elem_last;

    // Sequencer side: accepts instructions, produces status and beats.
    modport master (
        input  instr_valid, instr_word, instr_rs1_value, elem_ready,
        output instr_ready, vl, rd_valid, rd_addr, rd_value, illegal, done,
        output elem_valid, elem_funct6, elem_use_scalar, elem_scalar,
        output elem_vd, elem_vs1, elem_vs2, elem_dst_index, elem_src_index,
        output elem_src_zero, elem_last
    );

    // Pipeline side: offers instructions, consumes status and beats.
    modport slave (
        output instr_valid, instr_word, instr_rs1_value, elem_ready,
        input  instr_ready, vl, rd_valid, rd_addr, rd_value, illegal, done,
        input  elem_valid, elem_funct6, elem_use_scalar, elem_scalar,
        input  elem_vd, elem_vs1, elem_vs2, elem_dst_index, elem_src_index,
        input  elem_src_zero, elem_last
    );
endinterface

// File: rtl/rv32v_element_sequencer.sv
// Purpose: decode OP-V instructions, own the vl CSR, expand legal ops into one beat per element.
// Latency: decode results (illegal/done/writeback/first beat) one cycle after acceptance, then 1 beat/cycle.
// Backpressure: beats hold stable while elem_ready is low; instr_ready stays low for the whole beat stream.
module rv32v_element_sequencer #(
    parameter int VLMAX = 32
) (
    input  logic clk,
    input  logic rst,
    rv32v_element_sequencer_if.master bus
);
    localparam int VLW = $clog2(VLMAX) + 1;
    localparam int IW  = VLW - 1;
    // Wide enough for max element index plus a 31 slide offset, even for tiny VLMAX.
    localparam int SW  = (VLW >= 6) ? VLW + 1 : 7;

    localparam logic [6:0] OPC_OPV  = 7'b1010111;
    localparam logic [2:0] F3_OPFVV = 3'b001;
    localparam logic [2:0] F3_OPIVI = 3'b011;
    localparam logic [2:0] F3_OPFVF = 3'b101;
    localparam logic [2:0] F3_SETVL = 3'b111;

    localparam logic [5:0] F6_VFADD      = 6'b000000;
    localparam logic [5:0] F6_VFSUB      = 6'b000010;
    localparam logic [5:0] F6_VFMIN      = 6'b000100;
    localparam logic [5:0] F6_VFMAX      = 6'b000110;
    localparam logic [5:0] F6_VFSGNJ     = 6'b001000;
    localparam logic [5:0] F6_VFSGNJN    = 6'b001001;
    localparam logic [5:0] F6_VFSGNJX    = 6'b001010;
    localparam logic [5:0] F6_VSLIDEUP   = 6'b001110;
    localparam logic [5:0] F6_VSLIDEDOWN = 6'b001111;
    localparam logic [5:0] F6_VFDIV      = 6'b100000;
    localparam logic [5:0] F6_VFRDIV     = 6'b100001;
    localparam logic [5:0] F6_VFMUL      = 6'b100100;
    localparam logic [5:0] F6_VFMACC     = 6'b101100;
    localparam logic [5:0] F6_VFNMACC    = 6'b101101;
    localparam logic [5:0] F6_VFMSAC     = 6'b101110;
    localparam logic [5:0] F6_VFNMSAC    = 6'b101111;

    typedef enum logic {IDLE, ISSUE} state_t;
    typedef enum logic [1:0] {K_ELEM = 2'd0, K_SLIDEUP = 2'd1, K_SLIDEDOWN = 2'd2} kind_t;

    state_t state_q, state_d;

    // Instruction fields
    logic [5:0]     dec_funct6;
    logic           dec_vm;
    logic [4:0]     dec_vs2, dec_vs1, dec_vd;
    logic [2:0]     dec_funct3;
    logic [6:0]     dec_opcode;
    logic           dec_fp_op, dec_legal, dec_setvl, dec_empty;
    kind_t          dec_kind;
    logic [SW-1:0]  dec_start;
    logic [VLW-1:0] new_vl;

    // Architectural and in-flight op state
    logic [VLW-1:0] vl_q;
    logic           rd_valid_q, illegal_q, done_q;
    logic [4:0]     rd_addr_q;
    logic [31:0]    rd_value_q;
    logic [5:0]     op_funct6_q;
    logic           op_use_scalar_q;
    logic [31:0]    op_scalar_q;
    logic [4:0]     op_vd_q, op_vs1_q, op_vs2_q;
    kind_t          op_kind_q;
    logic [VLW-1:0] op_len_q;
    logic [VLW-1:0] cur_q;

    logic           accept, fire;
    logic [SW-1:0]  beat_sum;
    logic           beat_src_zero, beat_last;
    logic [IW-1:0]  beat_src;

    assign {dec_funct6, dec_vm, dec_vs2, dec_vs1, dec_funct3, dec_vd, dec_opcode} = bus.instr_word;

    // Unsigned clamp of the requested length to VLMAX.
    assign new_vl = (bus.instr_rs1_value > 32'(VLMAX)) ? VLW'(VLMAX) : bus.instr_rs1_value[VLW-1:0];

    // Legality check and op classification of the offered instruction.
    always_comb begin
        dec_fp_op = 1'b0;
        case (dec_funct6)
            F6_VFADD, F6_VFSUB, F6_VFMIN, F6_VFMAX, F6_VFSGNJ, F6_VFSGNJN, F6_VFSGNJX,
            F6_VFDIV, F6_VFMUL, F6_VFMACC, F6_VFNMACC, F6_VFMSAC, F6_VFNMSAC: dec_fp_op = 1'b1;
            default: dec_fp_op = 1'b0;
        endcase
        dec_legal = 1'b0;
        dec_setvl = 1'b0;
        dec_kind  = K_ELEM;
        if (dec_opcode == OPC_OPV) begin
            case (dec_funct3)
                F3_SETVL: begin
                    dec_setvl = 1'b1;
                    dec_legal = 1'b1;
                end
                F3_OPFVV: dec_legal = dec_vm && dec_fp_op;
                F3_OPFVF: dec_legal = dec_vm && (dec_fp_op || dec_funct6 == F6_VFRDIV);
                F3_OPIVI: begin
                    dec_legal = dec_vm && (dec_funct6 == F6_VSLIDEUP || dec_funct6 == F6_VSLIDEDOWN);
                    dec_kind  = (dec_funct6 == F6_VSLIDEUP) ? K_SLIDEUP : K_SLIDEDOWN;
                end
                default: dec_legal = 1'b0;
            endcase
        end
        // Slideup skips destinations below the offset; everything else starts at element 0.
        dec_start = (dec_kind == K_SLIDEUP) ? SW'(dec_vs1) : '0;
        dec_empty = (dec_start >= SW'(vl_q));
    end

    // Source index and last-beat flag for the current destination element.
    always_comb begin
        beat_sum      = SW'(cur_q) + SW'(op_vs1_q);
        beat_src_zero = 1'b0;
        beat_src      = cur_q[IW-1:0];
        case (op_kind_q)
            K_SLIDEUP: beat_src = IW'(SW'(cur_q) - SW'(op_vs1_q));
            K_SLIDEDOWN: begin
                if (beat_sum >= SW'(VLMAX)) begin
                    beat_src_zero = 1'b1;
                    beat_src      = '0;
                end else begin
                    beat_src = beat_sum[IW-1:0];
                end
            end
            default: ;
        endcase
        beat_last = ((SW'(cur_q) + SW'(1)) == SW'(op_len_q));
    end

    // FSM next state plus accept/beat-advance strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    accept = 1'b1;
                    if (dec_legal && !dec_setvl && !dec_empty) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.elem_ready) begin
                    fire = 1'b1;
                    if (beat_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // vl CSR, one-cycle pulses, latched op fields and element counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            vl_q            <= '0;
            rd_valid_q      <= 1'b0;
            rd_addr_q       <= '0;
            rd_value_q      <= '0;
            illegal_q       <= 1'b0;
            done_q          <= 1'b0;
            op_funct6_q     <= '0;
            op_use_scalar_q <= 1'b0;
            op_scalar_q     <= '0;
            op_vd_q         <= '0;
            op_vs1_q        <= '0;
            op_vs2_q        <= '0;
            op_kind_q       <= K_ELEM;
            op_len_q        <= '0;
            cur_q           <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            done_q     <= 1'b0;
            if (accept) begin
                if (!dec_legal) begin
                    illegal_q <= 1'b1;
                end else if (dec_setvl) begin
                    vl_q       <= new_vl;
                    rd_valid_q <= 1'b1;
                    rd_addr_q  <= dec_vd;
                    rd_value_q <= 32'(new_vl);
                    done_q     <= 1'b1;
                end else begin
                    op_funct6_q     <= dec_funct6;
                    op_use_scalar_q <= (dec_funct3 == F3_OPFVF);
                    op_scalar_q     <= bus.instr_rs1_value;
                    op_vd_q         <= dec_vd;
                    op_vs1_q        <= dec_vs1;
                    op_vs2_q        <= dec_vs2;
                    op_kind_q       <= dec_kind;
                    op_len_q        <= vl_q;
                    cur_q           <= dec_start[VLW-1:0];
                    if (dec_empty) done_q <= 1'b1;
                end
            end
            if (fire) begin
                if (beat_last) done_q <= 1'b1;
                else           cur_q  <= cur_q + VLW'(1);
            end
        end
    end

    assign bus.instr_ready     = (state_q == IDLE);
    assign bus.vl              = vl_q;
    assign bus.rd_valid        = rd_valid_q;
    assign bus.rd_addr         = rd_addr_q;
    assign bus.rd_value        = rd_value_q;
    assign bus.illegal         = illegal_q;
    assign bus.done            = done_q;
    assign bus.elem_valid      = (state_q == ISSUE);
    assign bus.elem_funct6     = op_funct6_q;
    assign bus.elem_use_scalar = op_use_scalar_q;
    assign bus.elem_scalar     = op_scalar_q;
    assign bus.elem_vd         = op_vd_q;
    assign bus.elem_vs1        = op_vs1_q;
    assign bus.elem_vs2        = op_vs2_q;
    assign bus.elem_dst_index  = cur_q[IW-1:0];
    assign bus.elem_src_index  = beat_src;
    assign bus.elem_src_zero   = beat_src_zero;
    assign bus.elem_last       = (state_q == ISSUE) && beat_last;
endmodule

// File: tb/tb_rv32v_element_sequencer.sv
// Purpose: randomized and directed self-checking bench for rv32v_element_sequencer.
// Latency: expects decode results one cycle after acceptance and one beat per ready cycle.
// Backpressure: drives elem_ready with fixed stalls or random gaps and checks beats hold while stalled.
`timescale 1ns/1ps
module tb_rv32v_element_sequencer;
    localparam int VLMAX = 32;
    localparam int VLW   = $clog2(VLMAX) + 1;
    localparam int DW    = VLW - 1;
    localparam logic [6:0] OPV = 7'h57;
    localparam logic [5:0] FP_OPS [13] = '{6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h09, 6'h0A,
                                           6'h20, 6'h24, 6'h2C, 6'h2D, 6'h2E, 6'h2F};

    typedef struct packed {
        logic [5:0]    f6;
        logic          us;
        logic [31:0]   sc;
        logic [4:0]    vd;
        logic [4:0]    vs1;
        logic [4:0]    vs2;
        logic [DW-1:0] dst;
        logic [DW-1:0] src;
        logic          sz;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32v_element_sequencer_if #(.VLMAX(VLMAX)) bus ();
    rv32v_element_sequencer #(.VLMAX(VLMAX)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // Reference model state and expectations
    int    model_vl = 0;
    beat_t exp_q[$];
    bit    exp_ill, exp_setvl;
    int    exp_nvl;

    // Observations of one instruction
    beat_t       obs_q[$];
    logic        s_ill, s_done, s_rdv, s_ev, ready_at_issue;
    logic [4:0]  s_rda;
    logic [31:0] s_rdval;
    logic [VLW-1:0] s_vl_end;
    int n_done, n_ill, n_rdv, done_cyc, unstable, post_beats, n_stall;
    bit timed_out;

    function automatic logic [31:0] mk(input logic [5:0] f6, input logic vm, input logic [4:0] vs2,
                                       input logic [4:0] vs1, input logic [2:0] f3, input logic [4:0] vd,
                                       input logic [6:0] op);
        return {f6, vm, vs2, vs1, f3, vd, op};
    endfunction

    function automatic beat_t cur_beat();
        beat_t b;
        b.f6 = bus.elem_funct6;      b.us  = bus.elem_use_scalar; b.sc  = bus.elem_scalar;
        b.vd = bus.elem_vd;          b.vs1 = bus.elem_vs1;        b.vs2 = bus.elem_vs2;
        b.dst = bus.elem_dst_index;  b.src = bus.elem_src_index;
        b.sz = bus.elem_src_zero;    b.last = bus.elem_last;
        return b;
    endfunction

    // Expected outcome of one instruction, from the architectural rules.
    task automatic model(input logic [31:0] iw, input logic [31:0] rs1);
        logic [5:0] f6;
        logic [2:0] f3;
        int imm;
        bit isfp;
        beat_t b;
        f6 = iw[31:26]; f3 = iw[14:12]; imm = int'(iw[19:15]);
        isfp = 0;
        foreach (FP_OPS[i]) if (FP_OPS[i] == f6) isfp = 1;
        exp_q.delete(); exp_setvl = 0; exp_ill = 1; exp_nvl = model_vl;
        if (iw[6:0] == OPV) begin
            if (f3 == 3'd7) begin
                exp_setvl = 1; exp_ill = 0;
                exp_nvl = (rs1 > VLMAX) ? VLMAX : int'(rs1);
            end else if (iw[25]) begin
                if (f3 == 3'd1 && isfp) exp_ill = 0;
                if (f3 == 3'd5 && (isfp || f6 == 6'h21)) exp_ill = 0;
                if (f3 == 3'd3 && (f6 == 6'h0E || f6 == 6'h0F)) exp_ill = 0;
            end
        end
        if (!exp_ill && !exp_setvl) begin
            for (int e = 0; e < model_vl; e++) begin
                int s;
                bit z;
                s = e; z = 0;
                if (f3 == 3'd3 && f6 == 6'h0E) begin
                    if (e < imm) continue;
                    s = e - imm;
                end else if (f3 == 3'd3 && f6 == 6'h0F) begin
                    s = e + imm;
                    if (s >= VLMAX) begin z = 1; s = 0; end
                end
                b.f6 = f6; b.us = (f3 == 3'd5); b.sc = rs1; b.vd = iw[11:7];
                b.vs1 = iw[19:15]; b.vs2 = iw[24:20];
                b.dst = DW'(e); b.src = DW'(s); b.sz = z; b.last = 0;
                exp_q.push_back(b);
            end
            if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
        end
    endtask

    // Offer one instruction and record everything the DUT does until it settles.
    // mode 0: always ready; 1: stall stall_len cycles on beat stall_beat; 2: random ready.
    task automatic drive(input logic [31:0] iw, input logic [31:0] rs1, input int mode,
                         input int stall_beat, input int stall_len);
        beat_t prev;
        bit prev_stalled, ready;
        int cyc, tail;
        obs_q.delete();
        n_done = 0; n_ill = 0; n_rdv = 0; done_cyc = -1; unstable = 0;
        post_beats = 0; n_stall = 0; timed_out = 0;
        prev = '0;
        @(negedge clk);
        ready_at_issue = bus.instr_ready;
        bus.instr_valid = 1'b1; bus.instr_word = iw; bus.instr_rs1_value = rs1; bus.elem_ready = 1'b0;
        @(negedge clk);
        bus.instr_valid = 1'b0; bus.instr_word = $urandom; bus.instr_rs1_value = $urandom;
        s_ill = bus.illegal; s_done = bus.done; s_rdv = bus.rd_valid; s_rda = bus.rd_addr;
        s_rdval = bus.rd_value; s_ev = bus.elem_valid;
        prev_stalled = 0; cyc = 0; tail = -1;
        while (tail != 0) begin
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (bus.illegal) n_ill++;
            if (bus.rd_valid) n_rdv++;
            if (bus.elem_valid) begin
                if (n_done > 0 || n_ill > 0) post_beats++;
                if (prev_stalled && cur_beat() != prev) unstable++;
                if (mode == 0) ready = 1;
                else if (mode == 1) ready = !(obs_q.size() == stall_beat && n_stall < stall_len);
                else ready = ($urandom_range(0, 3) != 0);
                if (!ready) n_stall++;
                else obs_q.push_back(cur_beat());
                prev = cur_beat();
                prev_stalled = !ready;
            end else begin
                ready = 1'($urandom_range(0, 1));
                prev_stalled = 0;
            end
            bus.elem_ready = ready;
            if (tail < 0 && (n_done > 0 || n_ill > 0)) tail = 3;
            else if (tail > 0) tail--;
            cyc++;
            if (cyc > 300) begin timed_out = 1; tail = 0; end
            if (tail != 0) @(negedge clk);
        end
        bus.elem_ready = 1'b0;
        s_vl_end = bus.vl;
    endtask

    task automatic set_vl(input int n);
        drive(mk(6'd0, 1'b1, 5'd0, 5'd0, 3'd7, 5'd0, OPV), 32'(n), 0, 0, 0);
        model_vl = n;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_vl = 0;
        n_vec++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_instr_ready got %b want 1", bus.instr_ready); end
        n_vec++; if (bus.vl !== '0) begin n_err++; $display("FAIL reset_vl got %0d want 0", bus.vl); end
        n_vec++; if (bus.elem_valid !== 1'b0) begin n_err++; $display("FAIL reset_elem_valid got %b want 0", bus.elem_valid); end
        n_vec++; if ({bus.rd_valid, bus.illegal, bus.done} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got %b want 000", {bus.rd_valid, bus.illegal, bus.done}); end
        n_vec++; if (bus.rd_value !== 32'd0 || bus.elem_last !== 1'b0 || bus.elem_src_zero !== 1'b0) begin n_err++; $display("FAIL reset_outputs rd_value %h last %b sz %b want 0", bus.rd_value, bus.elem_last, bus.elem_src_zero); end
    endtask

    task automatic test_setvl();
        logic [31:0] rs1_tab [8] = '{32'd100, 32'd0, 32'd32, 32'd33, 32'hFFFF_FFFF, 32'h8000_0000, 32'd31, 32'd1};
        logic [4:0]  vd_tab  [8] = '{5'd5, 5'd0, 5'd31, 5'd7, 5'd12, 5'd0, 5'd3, 5'd9};
        for (int i = 0; i < 8; i++) begin
            logic [31:0] iw;
            iw = mk(6'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 3'd7, vd_tab[i], OPV);
            model(iw, rs1_tab[i]);
            drive(iw, rs1_tab[i], 0, 0, 0);
            model_vl = exp_nvl;
            n_vec++; if (ready_at_issue !== 1'b1) begin n_err++; $display("FAIL setvl%0d_ready got %b want 1", i, ready_at_issue); end
            n_vec++; if ({s_rdv, s_done, s_ill} !== 3'b110) begin n_err++; $display("FAIL setvl%0d_pulses rdv/done/ill got %b want 110", i, {s_rdv, s_done, s_ill}); end
            n_vec++; if (s_rda !== vd_tab[i]) begin n_err++; $display("FAIL setvl%0d_rd_addr got %0d want %0d", i, s_rda, vd_tab[i]); end
            n_vec++; if (s_rdval !== 32'(exp_nvl)) begin n_err++; $display("FAIL setvl%0d_rd_value got %0d want %0d", i, s_rdval, exp_nvl); end
            n_vec++; if (s_vl_end !== VLW'(exp_nvl)) begin n_err++; $display("FAIL setvl%0d_vl got %0d want %0d", i, s_vl_end, exp_nvl); end
            n_vec++; if (obs_q.size() != 0 || n_done != 1 || n_rdv != 1) begin n_err++; $display("FAIL setvl%0d_extra beats %0d done %0d rdv %0d want 0 1 1", i, obs_q.size(), n_done, n_rdv); end
        end
    endtask

    task automatic test_fp_stall();
        logic [31:0] iw, rs1;
        set_vl(4);
        iw = mk(6'h00, 1'b1, 5'd3, 5'd2, 3'd1, 5'd1, OPV);
        rs1 = $urandom;
        model(iw, rs1);
        drive(iw, rs1, 1, 2, 3);
        n_vec++; if (s_ev !== 1'b1 || s_ill !== 1'b0) begin n_err++; $display("FAIL fp_first_beat valid %b ill %b want 1 0", s_ev, s_ill); end
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL fp_beat_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fp_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_vec++; if (unstable != 0 || n_stall != 3) begin n_err++; $display("FAIL fp_stall unstable %0d stalls %0d want 0 3", unstable, n_stall); end
        n_vec++; if (done_cyc != 7 || n_done != 1 || post_beats != 0) begin n_err++; $display("FAIL fp_done cyc %0d count %0d post %0d want 7 1 0", done_cyc, n_done, post_beats); end
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL fp_timeout got %b want 0", timed_out); end
    endtask

    task automatic test_slides();
        logic [5:0] f6_tab  [7] = '{6'h0F, 6'h0E, 6'h0E, 6'h0F, 6'h0E, 6'h0E, 6'h0F};
        logic [4:0] imm_tab [7] = '{5'd30, 5'd3, 5'd9, 5'd0, 5'd8, 5'd7, 5'd24};
        set_vl(8);
        for (int t = 0; t < 7; t++) begin
            logic [31:0] iw, rs1;
            iw = mk(f6_tab[t], 1'b1, 5'($urandom), imm_tab[t], 3'd3, 5'($urandom), OPV);
            rs1 = $urandom;
            model(iw, rs1);
            drive(iw, rs1, 0, 0, 0);
            n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL slide%0d_count got %0d want %0d", t, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL slide%0d_beat%0d got %h want %h", t, i, obs_q[i], exp_q[i]); end
            end
            n_vec++; if (done_cyc != exp_q.size() || n_done != 1 || post_beats != 0 || s_ill !== 1'b0) begin n_err++; $display("FAIL slide%0d_done cyc %0d count %0d post %0d ill %b want %0d 1 0 0", t, done_cyc, n_done, post_beats, s_ill, exp_q.size()); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] tab [9];
        tab[0] = mk(6'h21, 1'b1, 5'd3, 5'd2, 3'd1, 5'd1, OPV);
        tab[1] = mk(6'h00, 1'b1, 5'd3, 5'd2, 3'd3, 5'd1, OPV);
        tab[2] = mk(6'h24, 1'b0, 5'd3, 5'd2, 3'd1, 5'd1, OPV);
        tab[3] = mk(6'h00, 1'b1, 5'd3, 5'd2, 3'd0, 5'd1, OPV);
        tab[4] = mk(6'h00, 1'b1, 5'd3, 5'd2, 3'd1, 5'd1, 7'b0110011);
        tab[5] = mk(6'h00, 1'b1, 5'd3, 5'd2, 3'd2, 5'd1, OPV);
        tab[6] = mk(6'h00, 1'b1, 5'd3, 5'd2, 3'd4, 5'd1, OPV);
        tab[7] = mk(6'h00, 1'b1, 5'd3, 5'd2, 3'd6, 5'd1, OPV);
        tab[8] = mk(6'h0E, 1'b0, 5'd3, 5'd2, 3'd3, 5'd1, OPV);
        set_vl(8);
        for (int i = 0; i < 9; i++) begin
            drive(tab[i], 32'd5, 0, 0, 0);
            n_vec++; if (s_ill !== 1'b1 || n_ill != 1) begin n_err++; $display("FAIL illegal%0d_pulse first %b count %0d want 1 1", i, s_ill, n_ill); end
            n_vec++; if (n_done != 0 || obs_q.size() != 0 || n_rdv != 0) begin n_err++; $display("FAIL illegal%0d_side done %0d beats %0d rdv %0d want 0 0 0", i, n_done, obs_q.size(), n_rdv); end
            n_vec++; if (s_vl_end !== VLW'(model_vl)) begin n_err++; $display("FAIL illegal%0d_vl got %0d want %0d", i, s_vl_end, model_vl); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            logic [31:0] iw, rs1;
            int cls;
            logic vm;
            cls = $urandom_range(0, 9);
            vm = ($urandom_range(0, 7) != 0);
            rs1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            if (cls <= 1)
                iw = mk(6'($urandom), vm, 5'($urandom), 5'($urandom), 3'd7, 5'($urandom), OPV);
            else if (cls <= 4)
                iw = mk(($urandom_range(0, 13) == 13) ? 6'h21 : FP_OPS[$urandom_range(0, 12)], vm,
                        5'($urandom), 5'($urandom), ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd1, 5'($urandom), OPV);
            else if (cls <= 7)
                iw = mk(($urandom_range(0, 1) != 0) ? 6'h0E : 6'h0F, vm, 5'($urandom), 5'($urandom),
                        3'd3, 5'($urandom), OPV);
            else if (cls == 8)
                iw = {$urandom, OPV} >> 0;
            else
                iw = $urandom;
            if (cls == 8) iw[6:0] = OPV;
            model(iw, rs1);
            drive(iw, rs1, 2, 0, 0);
            if (exp_setvl) model_vl = exp_nvl;
            n_vec++; if (s_ill !== 1'(exp_ill)) begin n_err++; $display("FAIL rand%0d_illegal iw %h got %b want %b", it, iw, s_ill, exp_ill); end
            n_vec++; if (n_done != (exp_ill ? 0 : 1) || post_beats != 0 || timed_out) begin n_err++; $display("FAIL rand%0d_done iw %h count %0d post %0d timeout %b", it, iw, n_done, post_beats, timed_out); end
            n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d_count iw %h got %0d want %0d", it, iw, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_beat%0d got %h want %h", it, i, obs_q[i], exp_q[i]); end
            end
            n_vec++; if (unstable != 0 || (!exp_ill && done_cyc != exp_q.size() + n_stall)) begin n_err++; $display("FAIL rand%0d_timing unstable %0d done_cyc %0d want 0 %0d", it, unstable, done_cyc, exp_q.size() + n_stall); end
            n_vec++; if (s_vl_end !== VLW'(model_vl)) begin n_err++; $display("FAIL rand%0d_vl got %0d want %0d", it, s_vl_end, model_vl); end
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        int seen;
        set_vl(8);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_word = mk(6'h00, 1'b1, 5'd3, 5'd2, 3'd1, 5'd1, OPV);
        bus.instr_rs1_value = 32'd0;
        bus.elem_ready = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (bus.elem_valid && bus.elem_dst_index == DW'(2)) begin
                rst = 1'b1;
                hit = 1;
            end else begin
                @(negedge clk);
            end
        end
        n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL rstmid_reach_beat2 got %b want 1", hit); end
        @(negedge clk);
        rst = 1'b0;
        model_vl = 0;
        n_vec++; if (bus.elem_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_elem_valid got %b want 0", bus.elem_valid); end
        n_vec++; if (bus.vl !== '0) begin n_err++; $display("FAIL rstmid_vl got %0d want 0", bus.vl); end
        n_vec++; if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0) begin n_err++; $display("FAIL rstmid_ready_done got %b %b want 1 0", bus.instr_ready, bus.done); end
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done || bus.elem_valid) seen++;
        end
        bus.elem_ready = 1'b0;
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL rstmid_after got %0d done/beat cycles want 0", seen); end
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_word = '0;
        bus.instr_rs1_value = '0;
        bus.elem_ready = 1'b0;
        test_reset();
        test_setvl();
        test_fp_stall();
        test_slides();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
